// File: rtl/tick_divider.sv
// Multi-channel clock-enable generator: per-channel one-cycle tick and 50% square wave.
// Define TICK_DIVIDER_RUNTIME_EN to build the glitch-free runtime divisor write port.
module tick_divider #(
    parameter int unsigned CH      = 2,
    parameter int unsigned CNT_W   = 27,
    parameter logic [CH*CNT_W-1:0] DEF_DIV = {27'd400000, 27'd400000},
    localparam int unsigned SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    sq,
    output logic [CH-1:0]    div_pend
);

`ifdef TICK_DIVIDER_RUNTIME_EN
    logic             sel_ok;
    logic [CNT_W-1:0] wr_val;

    // Out-of-range channel indices are dropped; a divisor of 0 is stored as 1.
    assign sel_ok = (32'(div_sel) < CH);
    assign wr_val = (div_val == '0) ? CNT_W'(1) : div_val;
`else
    logic unused_wr;
    assign unused_wr = ^{div_wr, div_sel, div_val};
`endif

    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        localparam logic [CNT_W-1:0] DEF_I   = DEF_DIV[i*CNT_W +: CNT_W];
        localparam logic [CNT_W-1:0] DIV_RST = (DEF_I == '0) ? CNT_W'(1) : DEF_I;

        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_cur;
        logic             tick_q;
        logic             sq_q;
        logic             tc;

        assign tc = en[i] && (cnt == div_cur - CNT_W'(1));

`ifdef TICK_DIVIDER_RUNTIME_EN
        logic [CNT_W-1:0] div_nxt;
        logic             pend_q;
        logic             wr_hit;

        assign wr_hit = div_wr && sel_ok && (div_sel == SEL_W'(i));

        // New divisors only take effect at a wrap or while halted, so no short period.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt     <= '0;
                div_cur <= DIV_RST;
                div_nxt <= DIV_RST;
                pend_q  <= 1'b0;
                tick_q  <= 1'b0;
                sq_q    <= 1'b0;
            end else begin
                tick_q <= tc;
                if (tc) begin
                    cnt  <= '0;
                    sq_q <= ~sq_q;
                    if (wr_hit) begin
                        div_cur <= wr_val;
                        pend_q  <= 1'b0;
                    end else if (pend_q) begin
                        div_cur <= div_nxt;
                        pend_q  <= 1'b0;
                    end
                end else begin
                    if (en[i]) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (pend_q) begin
                        div_cur <= div_nxt;
                        cnt     <= '0;
                        pend_q  <= 1'b0;
                    end
                    // A write here supersedes anything still pending (last write wins).
                    if (wr_hit) begin
                        div_nxt <= wr_val;
                        pend_q  <= 1'b1;
                    end
                end
            end
        end

        assign div_pend[i] = pend_q;
`else
        assign div_cur = DIV_RST;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                tick_q <= tc;
                if (tc) begin
                    cnt  <= '0;
                    sq_q <= ~sq_q;
                end else if (en[i]) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign div_pend[i] = 1'b0;
`endif

        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule

// File: tb/tb_tick_divider.sv
// Randomized bench for tick_divider against a countdown-based reference model.
module tb_tick_divider;
    localparam int unsigned CH    = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEL_W = 2;
    localparam logic [CH*CNT_W-1:0] DEF = {8'd0, 8'd3, 8'd5};
`ifdef TICK_DIVIDER_RUNTIME_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    en;
    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_val;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    sq;
    logic [CH-1:0]    div_pend;

    tick_divider #(.CH(CH), .CNT_W(CNT_W), .DEF_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .div_wr(div_wr), .div_sel(div_sel),
        .div_val(div_val), .tick(tick), .sq(sq), .div_pend(div_pend)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: cycles remaining until the next tick, the active period and an optional pending period.
    int rem [CH];
    int per [CH];
    int nxt [CH];
    bit has [CH];
    bit m_tick [CH];
    bit m_sq [CH];

    function automatic int clamp(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int def_div(input int c);
        logic [CH*CNT_W-1:0] d;
        d = DEF;
        return clamp(int'(d[c*CNT_W +: CNT_W]));
    endfunction

    task automatic model_step();
        for (int c = 0; c < int'(CH); c++) begin
            bit wr;
            int v;
            if (rst) begin
                per[c] = def_div(c);
                rem[c] = per[c];
                has[c] = 1'b0;
                m_tick[c] = 1'b0;
                m_sq[c] = 1'b0;
                continue;
            end
            wr = RT && div_wr && (int'(div_sel) == c);
            v  = clamp(int'(div_val));
            if (en[c]) begin
                if (rem[c] == 1) begin
                    m_tick[c] = 1'b1;
                    m_sq[c] = ~m_sq[c];
                    if (wr) begin
                        per[c] = v;
                        has[c] = 1'b0;
                    end else if (has[c]) begin
                        per[c] = nxt[c];
                        has[c] = 1'b0;
                    end
                    rem[c] = per[c];
                end else begin
                    rem[c] = rem[c] - 1;
                    m_tick[c] = 1'b0;
                    if (wr) begin
                        nxt[c] = v;
                        has[c] = 1'b1;
                    end
                end
            end else begin
                m_tick[c] = 1'b0;
                if (has[c]) begin
                    per[c] = nxt[c];
                    rem[c] = per[c];
                    has[c] = 1'b0;
                end
                if (wr) begin
                    nxt[c] = v;
                    has[c] = 1'b1;
                end
            end
        end
    endtask

    // One clock: advance model with the applied inputs, then compare after the edge.
    task automatic step_and_check();
        logic [CH-1:0] et, es, ep;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        for (int c = 0; c < int'(CH); c++) begin
            et[c] = m_tick[c];
            es[c] = m_sq[c];
            ep[c] = has[c];
        end
        check("tick", 32'(tick), 32'(et));
        check("sq", 32'(sq), 32'(es));
        check("div_pend", 32'(div_pend), 32'(ep));
    endtask

    int tick_cnt [CH];

    initial begin
        rst = 1'b1;
        en = '1;
        div_wr = 1'b0;
        div_sel = '0;
        div_val = '0;
        for (int c = 0; c < int'(CH); c++) begin
            tick_cnt[c] = 0;
            has[c] = 1'b0;
        end
        repeat (3) step_and_check();

        // Free run from reset release: 30 edges give 6, 10 and 30 ticks for divisors 5, 3, 1.
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step_and_check();
            for (int c = 0; c < int'(CH); c++) tick_cnt[c] += int'(tick[c]);
        end
        check("ticks_ch0", 32'(tick_cnt[0]), 32'd6);
        check("ticks_ch1", 32'(tick_cnt[1]), 32'd10);
        check("ticks_ch2", 32'(tick_cnt[2]), 32'd30);

        // Randomized run: mostly enabled channels, sparse writes incl. divisor 0 and channel 3, rare resets.
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < int'(CH); c++) en[c] = ($urandom_range(0, 7) != 0);
            div_wr  = ($urandom_range(0, 5) == 0);
            div_sel = SEL_W'($urandom_range(0, 3));
            div_val = CNT_W'($urandom_range(0, 9));
            step_and_check();
            div_wr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
